// File: rtl/ext_pipe.sv
// Pipelined immediate/field extender with a 2-entry elastic output buffer.
// Define EXT_PIPE_PERF_CNT_EN to add the perf_xfer/perf_stall counters.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
`ifdef EXT_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_xfer,
    output logic [31:0]      perf_stall
`endif
);

    generate
        if (OUT_W < IN_W + 2 || IN_W < 8) begin : g_bad_width
            $error("ext_pipe: requires OUT_W >= IN_W+2 and IN_W >= 8");
        end
    endgenerate

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;

    assign sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_op)
            3'b000:  ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
            3'b001:  ext_data = sext;
            3'b010:  ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
            3'b011:  ext_data = sext << 2;
            3'b100:  ext_data = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
            3'b101:  ext_data = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
            default: ext_err  = 1'b1;
        endcase
    end

    logic [OUT_W-1:0] data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             err_q  [2];
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             accept;
    logic             pop;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // in_ready comes only from count_q, never from out_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data = data_q[rd_ptr_q];
    assign out_tag  = tag_q[rd_ptr_q];
    assign out_err  = err_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q ^ accept;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (accept && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !accept) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (accept) begin
                data_q[wr_ptr_q] <= ext_data;
                tag_q[wr_ptr_q]  <= in_tag;
                err_q[wr_ptr_q]  <= ext_err;
            end
        end
    end

`ifdef EXT_PIPE_PERF_CNT_EN
    logic [31:0] perf_xfer_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_xfer_q  <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (pop) begin
                perf_xfer_q <= perf_xfer_q + 32'd1;
            end
            if (in_valid && !in_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_xfer  = perf_xfer_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: drivers push expected entries on accept,
// a negedge monitor pops and compares on every output transfer.
module tb_ext_pipe;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;
    localparam int EW    = 1 + TAG_W + OUT_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
`ifdef EXT_PIPE_PERF_CNT_EN
    logic [31:0]      perf_xfer;
    logic [31:0]      perf_stall;
    logic [31:0]      xfer_base;
    logic [31:0]      stall_base;
`endif

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    bit stream_done;

    ext_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_err(out_err)
`ifdef EXT_PIPE_PERF_CNT_EN
        , .perf_xfer(perf_xfer), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [IN_W-1:0] imm, input logic [2:0] op,
                        input logic [TAG_W-1:0] tag, input logic [OUT_W-1:0] exp_d,
                        input logic exp_e);
        bit done = 0;
        bit acc;
        in_valid = 1'b1;
        in_imm   = imm;
        in_op    = op;
        in_tag   = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back({exp_e, tag, exp_d});
                done = 1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: imm %0h not accepted, got stuck expected accept", imm);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %0h expected none", out_data);
            end else begin
                chk("out_entry", 64'({out_err, out_tag, out_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_data",  64'(out_data),  64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Mode sweep
        out_ready = 1'b1;
        send(16'h8001, 3'b000, 5'd7, 32'h0000_8001, 1'b0); chk("lat_zext", 64'(out_valid), 64'd1);
        send(16'h8001, 3'b001, 5'd7, 32'hFFFF_8001, 1'b0); chk("lat_sext", 64'(out_valid), 64'd1);
        send(16'h8001, 3'b010, 5'd7, 32'h8001_0000, 1'b0); chk("lat_upper", 64'(out_valid), 64'd1);
        send(16'h8001, 3'b011, 5'd7, 32'hFFFE_0004, 1'b0); chk("lat_branch", 64'(out_valid), 64'd1);
        send(16'h8001, 3'b100, 5'd7, 32'h0000_0001, 1'b0); chk("lat_sext8a", 64'(out_valid), 64'd1);
        send(16'h00F0, 3'b100, 5'd7, 32'hFFFF_FFF0, 1'b0); chk("lat_sext8b", 64'(out_valid), 64'd1);
        send(16'h00F0, 3'b101, 5'd7, 32'h0000_00F0, 1'b0); chk("lat_zext8", 64'(out_valid), 64'd1);
        // Reserved modes then a normal one
        send(16'h1234, 3'b110, 5'd3, 32'h0000_0000, 1'b1);
        send(16'h1234, 3'b111, 5'd4, 32'h0000_0000, 1'b1);
        send(16'h1234, 3'b001, 5'd5, 32'h0000_1234, 1'b0);
        drain();

        // Backpressure
`ifdef EXT_PIPE_PERF_CNT_EN
        xfer_base  = perf_xfer;
        stall_base = perf_stall;
`endif
        out_ready = 1'b0;
        send(16'd1, 3'b000, 5'd1, 32'd1, 1'b0);
        send(16'd2, 3'b000, 5'd2, 32'd2, 1'b0);
        fork
            send(16'd3, 3'b000, 5'd3, 32'd3, 1'b0);
        join_none
        @(negedge clk);
        chk("bp_in_ready_a", 64'(in_ready),  64'd0);
        chk("bp_out_valid",  64'(out_valid), 64'd1);
        chk("bp_hold_a",     64'(out_data),  64'd1);
        @(negedge clk);
        chk("bp_in_ready_b", 64'(in_ready),  64'd0);
        chk("bp_hold_b",     64'(out_data),  64'd1);
        chk("bp_hold_tag",   64'(out_tag),   64'd1);
`ifdef EXT_PIPE_PERF_CNT_EN
        chk("perf_stall", 64'(perf_stall - stall_base), 64'd1);
`endif
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 20 && in_valid; i++) @(posedge clk);
        #2;
        drain();
`ifdef EXT_PIPE_PERF_CNT_EN
        chk("perf_xfer", 64'(perf_xfer - xfer_base), 64'd3);
`endif

        // Simultaneous accept and pop with a toggling consumer
        stream_done = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] v;
                    v = 16'h8000 | 16'(i * 16'h0111);
                    if (i % 2 == 0) send(v, 3'b000, 5'(i), {16'h0000, v}, 1'b0);
                    else            send(v, 3'b001, 5'(i), {16'hFFFF, v}, 1'b0);
                end
                stream_done = 1;
            end
            begin
                for (int c = 0; c < 200 && !stream_done; c++) begin
                    @(posedge clk);
                    #1 out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with two entries held
        out_ready = 1'b0;
        send(16'hAAAA, 3'b000, 5'd9,  32'h0000_AAAA, 1'b0);
        send(16'hBBBB, 3'b000, 5'd10, 32'h0000_BBBB, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready",  64'(in_ready),  64'd1);
        chk("ar_out_data",  64'(out_data),  64'd0);
        chk("ar_out_tag",   64'(out_tag),   64'd0);
        chk("ar_out_err",   64'(out_err),   64'd0);
        exp_q.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(16'h0042, 3'b101, 5'd11, 32'h0000_0042, 1'b0);
        chk("ar_first_lat", 64'(out_valid), 64'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
